// File: rtl/axis_byte_packer_pkg.sv
// Shared types for the UART byte packer: FSM state encoding and byte width.
package axis_byte_packer_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      EMIT = 2'd2
   } state_t;

endpackage

// File: rtl/axis_byte_packer.sv
// Packs UART bytes big-endian into BYTES_PER_WORD-byte AXI-Stream words.
// Define PACKER_TIMEOUT_EN to drop partial words after TIMEOUT_CYCLES idle clocks.
module axis_byte_packer
   import axis_byte_packer_pkg::*;
#(
   parameter int BYTES_PER_WORD = 4,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic                                   clk,
   input  logic                                   arstn,
   input  logic [BYTE_W-1:0]                      s_axis_tdata,
   input  logic                                   s_axis_tvalid,
   output logic                                   s_axis_tready,
   input  logic                                   rx_frame_error,
   output logic [BYTE_W*BYTES_PER_WORD-1:0]       m_axis_tdata,
   output logic                                   m_axis_tvalid,
   input  logic                                   m_axis_tready,
   output logic [$clog2(BYTES_PER_WORD+1)-1:0]    fill_level,
   output logic                                   discard
);

   localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
   localparam int ACC_W  = BYTE_W * (BYTES_PER_WORD - 1);
   localparam int FILL_W = $clog2(BYTES_PER_WORD + 1);
   localparam logic [FILL_W-1:0] LAST = FILL_W'(BYTES_PER_WORD - 1);

   if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 24'hFF_FFFF) begin : g_bad_param
      $error("axis_byte_packer: parameter out of range");
   end

   state_t              state;
   logic [ACC_W-1:0]    acc, acc_nxt;
   logic [FILL_W-1:0]   fill, fill_nxt;
   logic [WORD_W-1:0]   data_nxt;
   logic                vld_nxt, disc_nxt;
   logic                in_hs, out_hs, word_done, timeout_hit;

   // Only the last free accumulator slot can stall, and only if the output is stuck.
   assign s_axis_tready = !(fill == LAST && m_axis_tvalid && !m_axis_tready);
   assign in_hs         = s_axis_tvalid && s_axis_tready;
   assign out_hs        = m_axis_tvalid && m_axis_tready;
   assign word_done     = in_hs && !rx_frame_error && fill == LAST;
   assign m_axis_tvalid = (state == EMIT);
   assign fill_level    = fill;

`ifdef PACKER_TIMEOUT_EN
   logic [23:0] idle_cnt;

   assign timeout_hit = fill != '0 && !in_hs && idle_cnt == 24'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)
         idle_cnt <= '0;
      else if (rx_frame_error || in_hs || fill == '0 || timeout_hit)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 24'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      acc_nxt  = acc;
      fill_nxt = fill;
      data_nxt = m_axis_tdata;
      vld_nxt  = m_axis_tvalid && !out_hs;
      disc_nxt = 1'b0;
      // A framing error wins over a coincident byte, which is dropped with the partial word.
      if (rx_frame_error) begin
         acc_nxt  = '0;
         fill_nxt = '0;
         disc_nxt = (fill != '0);
      end else if (timeout_hit) begin
         acc_nxt  = '0;
         fill_nxt = '0;
         disc_nxt = 1'b1;
      end else if (word_done) begin
         data_nxt = {acc, s_axis_tdata};
         vld_nxt  = 1'b1;
         acc_nxt  = '0;
         fill_nxt = '0;
      end else if (in_hs) begin
         acc_nxt  = ACC_W'({acc, s_axis_tdata});
         fill_nxt = fill + FILL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state        <= IDLE;
         acc          <= '0;
         fill         <= '0;
         m_axis_tdata <= '0;
         discard      <= 1'b0;
      end else begin
         acc          <= acc_nxt;
         fill         <= fill_nxt;
         m_axis_tdata <= data_nxt;
         discard      <= disc_nxt;
         if (vld_nxt)
            state <= EMIT;
         else if (fill_nxt != '0)
            state <= FILL;
         else
            state <= IDLE;
      end
   end

endmodule
